// File: rtl/cpu_defs.sv
// Shared encodings for the controller: instruction fields, FSM states, datapath select codes.
package cpu_defs;

  localparam int INSTR_W = 16;
  localparam int STATE_W = 3;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] R4 = 3'd4;
  localparam logic [2:0] R5 = 3'd5;
  localparam logic [2:0] R6 = 3'd6;
  localparam logic [2:0] R7 = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_CALC      = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_MOV_IMM = 3'd1,
    CLS_MOV_REG = 3'd2,
    CLS_ADD     = 3'd3,
    CLS_CMP     = 3'd4,
    CLS_AND     = 3'd5,
    CLS_MVN     = 3'd6
  } iclass_t;

  function automatic logic [INSTR_W-1:0] sext8(input logic [7:0] v);
    return {{(INSTR_W-8){v[7]}}, v};
  endfunction

  function automatic logic [INSTR_W-1:0] sext5(input logic [4:0] v);
    return {{(INSTR_W-5){v[4]}}, v};
  endfunction

endpackage

// File: rtl/cpu_decoder.sv
// Combinational instruction field extraction and classification; unknown opcode/op pairs map to CLS_NOP.
module cpu_decoder
  import cpu_defs::*;
#(
  parameter int INSTR_W = 16
) (
  input  logic [INSTR_W-1:0] ir,
  output logic [1:0]         op,
  output logic [2:0]         rn,
  output logic [2:0]         rd,
  output logic [2:0]         rm,
  output logic [1:0]         sh,
  output logic [INSTR_W-1:0] sximm8,
  output logic [INSTR_W-1:0] sximm5,
  output iclass_t            iclass
);

  logic [2:0] opcode;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm8 = sext8(ir[7:0]);
  assign sximm5 = sext5(ir[4:0]);

  always_comb begin
    iclass = CLS_NOP;
    case (opcode)
      OPC_MOV: begin
        if (op == OP_MOV_IMM)      iclass = CLS_MOV_IMM;
        else if (op == OP_MOV_REG) iclass = CLS_MOV_REG;
      end
      OPC_ALU: begin
        case (op)
          OP_ADD:  iclass = CLS_ADD;
          OP_CMP:  iclass = CLS_CMP;
          OP_AND:  iclass = CLS_AND;
          default: iclass = CLS_MVN;
        endcase
      end
      default: iclass = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus Moore FSM sequencing datapath strobes for MOV/ADD/CMP/AND/MVN.
// Outputs depend only on state and IR; load and s are honoured only in WAIT.
module cpu_controller
  import cpu_defs::*;
#(
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] in,
  input  logic               load,
  input  logic               s,
  output logic               w,
  output logic [2:0]         readnum,
  output logic [2:0]         writenum,
  output logic               write,
  output logic [1:0]         vsel,
  output logic               loada,
  output logic               loadb,
  output logic               loadc,
  output logic               loads,
  output logic               asel,
  output logic               bsel,
  output logic [1:0]         shift,
  output logic [1:0]         ALUop,
  output logic [INSTR_W-1:0] sximm8,
  output logic [INSTR_W-1:0] sximm5
);

  logic [INSTR_W-1:0] ir;
  state_t             state;
  state_t             state_nxt;
  logic [1:0]         op;
  logic [2:0]         rn;
  logic [2:0]         rd;
  logic [2:0]         rm;
  logic [1:0]         sh;
  iclass_t            iclass;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir    <= '0;
      state <= S_WAIT;
    end else begin
      state <= state_nxt;
      if (load && state == S_WAIT) ir <= in;
    end
  end

  cpu_decoder #(.INSTR_W(INSTR_W)) u_dec (
    .ir     (ir),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (sh),
    .sximm8 (sximm8),
    .sximm5 (sximm5),
    .iclass (iclass)
  );

  always_comb begin
    state_nxt = state;
    w         = 1'b0;
    readnum   = R0;
    writenum  = R0;
    write     = 1'b0;
    vsel      = VSEL_C;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    shift     = SH_NONE;
    ALUop     = ALU_ADD;
    case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (iclass)
          CLS_MOV_IMM:                 state_nxt = S_WRITE_IMM;
          CLS_MOV_REG, CLS_MVN:        state_nxt = S_GET_B;
          CLS_ADD, CLS_CMP, CLS_AND:   state_nxt = S_GET_A;
          default:                     state_nxt = S_WAIT;
        endcase
      end
      S_WRITE_IMM: begin
        writenum  = rn;
        vsel      = VSEL_IMM8;
        write     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_GET_A: begin
        readnum   = rn;
        loada     = 1'b1;
        state_nxt = S_GET_B;
      end
      S_GET_B: begin
        readnum   = rm;
        loadb     = 1'b1;
        state_nxt = S_CALC;
      end
      S_CALC: begin
        shift = sh;
        // MOV reg passes B through the adder with A forced to zero
        case (iclass)
          CLS_MOV_REG: begin
            asel  = 1'b1;
            ALUop = ALU_ADD;
            loadc = 1'b1;
          end
          CLS_CMP: begin
            ALUop = ALU_SUB;
            loads = 1'b1;
          end
          default: begin
            ALUop = op;
            loadc = 1'b1;
          end
        endcase
        state_nxt = (iclass == CLS_CMP) ? S_WAIT : S_WRITE_REG;
      end
      S_WRITE_REG: begin
        writenum  = rd;
        vsel      = VSEL_C;
        write     = 1'b1;
        state_nxt = S_WAIT;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench: stimulus queues per-cycle expected outputs, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_cpu_controller;

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] shift;
    logic [1:0] aluop;
  } out_t;

  typedef struct {
    string       name;
    out_t        o;
    bit          chk;
    logic [15:0] i8;
    logic [15:0] i5;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] instr;
  logic        load;
  logic        s;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, aluop;
  logic [15:0] sximm8, sximm5;
  out_t        act;

  int tests = 0;
  int fails = 0;
  exp_t scb[$];
  exp_t seq[$];

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in       (instr),
    .load     (load),
    .s        (s),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .shift    (shift),
    .ALUop    (aluop),
    .sximm8   (sximm8),
    .sximm5   (sximm5)
  );

  assign act = {w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
                asel, bsel, shift, aluop};

  function automatic out_t o_wait();
    out_t o = '0;
    o.w = 1'b1;
    return o;
  endfunction
  function automatic out_t o_dec();
    out_t o = '0;
    return o;
  endfunction
  function automatic out_t o_wimm(input logic [2:0] rn);
    out_t o = '0;
    o.writenum = rn; o.vsel = 2'b10; o.write = 1'b1;
    return o;
  endfunction
  function automatic out_t o_geta(input logic [2:0] rn);
    out_t o = '0;
    o.readnum = rn; o.loada = 1'b1;
    return o;
  endfunction
  function automatic out_t o_getb(input logic [2:0] rm);
    out_t o = '0;
    o.readnum = rm; o.loadb = 1'b1;
    return o;
  endfunction
  function automatic out_t o_calc(input logic [1:0] sh, input logic [1:0] alu,
                                  input logic a, input logic lc, input logic ls);
    out_t o = '0;
    o.shift = sh; o.aluop = alu; o.asel = a; o.loadc = lc; o.loads = ls;
    return o;
  endfunction
  function automatic out_t o_wreg(input logic [2:0] rd);
    out_t o = '0;
    o.writenum = rd; o.write = 1'b1;
    return o;
  endfunction

  task automatic add(input string nm, input out_t o);
    seq.push_back('{nm, o, 1'b0, 16'h0, 16'h0});
  endtask
  task automatic add_imm(input string nm, input out_t o, input logic [15:0] i8, input logic [15:0] i5);
    seq.push_back('{nm, o, 1'b1, i8, i5});
  endtask

  task automatic check(input exp_t e);
    tests++;
    if (act !== e.o) begin
      fails++;
      $display("FAIL %s: outputs got %h expected %h", e.name, act, e.o);
    end
    if (e.chk) begin
      tests++;
      if ({sximm8, sximm5} !== {e.i8, e.i5}) begin
        fails++;
        $display("FAIL %s_imm: sximm8/5 got %h/%h expected %h/%h", e.name, sximm8, sximm5, e.i8, e.i5);
      end
    end
  endtask

  always @(negedge clk) begin
    if (scb.size() > 0) check(scb.pop_front());
  end

  // Called at posedge+1 while in WAIT; seq[0] is that WAIT cycle.
  task automatic issue(input logic [15:0] ins, input logic ld, input int glitch);
    int n;
    n = seq.size();
    instr = ins; load = ld; s = 1'b1;
    for (int i = 0; i < n; i++) begin
      scb.push_back(seq[i]);
      if (i == glitch) begin
        load = 1'b1; instr = 16'hFFFF;
      end
      @(posedge clk); #1;
      load = 1'b0;
    end
    seq.delete();
  endtask

  task automatic idle(input int n);
    s = 1'b0; load = 1'b0;
    for (int i = 0; i < n; i++) begin
      scb.push_back('{"idle", o_wait(), 1'b0, 16'h0, 16'h0});
      @(posedge clk); #1;
    end
  endtask

  task automatic seq_add_a148(input string p);
    add({p, "_wait"}, o_wait());
    add({p, "_dec"}, o_dec());
    add({p, "_geta"}, o_geta(3'd1));
    add({p, "_getb"}, o_getb(3'd0));
    add_imm({p, "_calc"}, o_calc(2'b01, 2'b00, 1'b0, 1'b1, 1'b0), 16'h0048, 16'h0008);
    add({p, "_wreg"}, o_wreg(3'd2));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; instr = 16'h0; load = 1'b0; s = 1'b0;
    #3;
    check('{"reset", o_wait(), 1'b1, 16'h0, 16'h0});
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(2);

    // MOV R0,#7 with load and s together
    add("movi7_wait", o_wait());
    add("movi7_dec", o_dec());
    add_imm("movi7_wimm", o_wimm(3'd0), 16'h0007, 16'h0007);
    issue(16'hD007, 1'b1, -1);

    // MOV R5,#-3
    add("movim3_wait", o_wait());
    add("movim3_dec", o_dec());
    add_imm("movim3_wimm", o_wimm(3'd5), 16'hFFFD, 16'hFFFD);
    issue(16'hD5FD, 1'b1, -1);

    seq_add_a148("add");
    issue(16'hA148, 1'b1, -1);

    // CMP R3,R3: no write cycle
    add("cmp_wait", o_wait());
    add("cmp_dec", o_dec());
    add("cmp_geta", o_geta(3'd3));
    add("cmp_getb", o_getb(3'd3));
    add("cmp_calc", o_calc(2'b00, 2'b01, 1'b0, 1'b0, 1'b1));
    issue(16'hAB03, 1'b1, -1);

    // MOV R1,R7
    add("movr_wait", o_wait());
    add("movr_dec", o_dec());
    add("movr_getb", o_getb(3'd7));
    add("movr_calc", o_calc(2'b00, 2'b00, 1'b1, 1'b1, 1'b0));
    add("movr_wreg", o_wreg(3'd1));
    issue(16'hC027, 1'b1, -1);

    // AND R7,R2,R1
    add("and_wait", o_wait());
    add("and_dec", o_dec());
    add("and_geta", o_geta(3'd2));
    add("and_getb", o_getb(3'd1));
    add("and_calc", o_calc(2'b00, 2'b10, 1'b0, 1'b1, 1'b0));
    add("and_wreg", o_wreg(3'd7));
    issue(16'hB2E1, 1'b1, -1);

    // MVN R4,R6,LSR#1
    add("mvn_wait", o_wait());
    add("mvn_dec", o_dec());
    add("mvn_getb", o_getb(3'd6));
    add("mvn_calc", o_calc(2'b10, 2'b11, 1'b0, 1'b1, 1'b0));
    add("mvn_wreg", o_wreg(3'd4));
    issue(16'hB896, 1'b1, -1);

    // load of FFFF during GET_B must be ignored; rerun without load re-executes the ADD
    seq_add_a148("addg");
    issue(16'hA148, 1'b1, 3);
    seq_add_a148("addkeep");
    issue(16'hFFFF, 1'b0, -1);

    // unsupported opcode 111: DECODE then straight back to WAIT
    add("nop_wait", o_wait());
    add("nop_dec", o_dec());
    issue(16'hE000, 1'b1, -1);
    idle(2);

    // async reset in GET_B of an ADD
    instr = 16'hA148; load = 1'b1; s = 1'b1;
    scb.push_back('{"rst_add_wait", o_wait(), 1'b0, 16'h0, 16'h0});
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0;
    scb.push_back('{"rst_add_dec", o_dec(), 1'b0, 16'h0, 16'h0});
    @(posedge clk); #1;
    scb.push_back('{"rst_add_geta", o_geta(3'd1), 1'b0, 16'h0, 16'h0});
    @(posedge clk); #1;
    #2 reset_n = 1'b0;
    #1 check('{"async_reset", o_wait(), 1'b1, 16'h0, 16'h0});
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(4);

    for (int i = 0; i < 5 && scb.size() > 0; i++) @(negedge clk);
    if (scb.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expected records left, required 0", scb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Control unit that drives the existing datapath's control inputs. It is the initiator side of the interface the datapath responds to. It latches a 16-bit instruction, decodes it, and sequences a Moore FSM. The FSM issues the per-cycle register-read, A/B/C/status-load and register-write strobes for MOV-immediate, MOV-register, ADD, CMP, AND and MVN. It sits between the instruction source (switches or a later fetch unit) and the datapath.

Parameters:
INSTR_W, 16, instruction and immediate-extension width
STATE_W, 3, state register width (7 states used)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
in  in  16  instruction word
load  in  1  capture `in` into instruction register (honoured only in WAIT)
s  in  1  start execution of the held instruction (honoured only in WAIT)
w  out  1  idle/ready flag, high only in WAIT
readnum  out  3  register file read address
writenum  out  3  register file write address
write  out  1  register file write enable
vsel  out  2  writeback select: 00 = C, 10 = sximm8 (01/11 never driven)
loada  out  1  load A register
loadb  out  1  load B register
loadc  out  1  load C register
loads  out  1  load status register
asel  out  1  1 forces ALU A input to 0
bsel  out  1  1 selects sximm5 as B input (always 0 for this instruction set)
shift  out  2  shifter op, taken from IR[4:3]
ALUop  out  2  00 add, 01 sub, 10 and, 11 not
sximm8  out  16  sign-extended IR[7:0]
sximm5  out  16  sign-extended IR[4:0]

Behaviour:
- Reset (async, reset_n=0): IR=16'h0000, state=WAIT. Every strobe, select and address output is 0, and w=1. Reset mid-instruction aborts it immediately; no partial write completes after reset asserts.
- IR encoding: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm.
- Supported instructions:
  - 110/10 MOV Rn,#imm8.
  - 110/00 MOV Rd,Rm{,sh}.
  - 101/00 ADD Rd,Rn,Rm{,sh}.
  - 101/01 CMP Rn,Rm{,sh}.
  - 101/10 AND Rd,Rn,Rm{,sh}.
  - 101/11 MVN Rd,Rm{,sh}.
- IR loads on a clk edge with load=1 only while state=WAIT; otherwise load is ignored.
- sximm8 and sximm5 are combinational from IR.
- Outputs are Moore: a function of state and IR only. Any strobe not listed for a state is 0; readnum and writenum are 0 unless listed.
- States and transitions:
  - WAIT: w=1. If s=1 go to DECODE, else stay. When load and s are high together, the new IR is the one executed.
  - DECODE: no strobes.
    - MOV imm -> WRITE_IMM.
    - MOV reg or MVN -> GET_B.
    - ADD, CMP or AND -> GET_A.
    - Any other opcode/op -> WAIT (no-op; no register or status change).
  - WRITE_IMM: writenum=Rn, vsel=10, write=1 -> WAIT.
  - GET_A: readnum=Rn, loada=1 -> GET_B.
  - GET_B: readnum=Rm, loadb=1 -> CALC.
  - CALC: shift=sh, bsel=0.
    - MOV reg: asel=1, ALUop=00, loadc=1.
    - ADD/AND/MVN: asel=0, ALUop=op, loadc=1.
    - CMP: asel=0, ALUop=01, loads=1, loadc=0.
    - Next: CMP -> WAIT, else -> WRITE_REG.
  - WRITE_REG: writenum=Rd, vsel=00, write=1 -> WAIT.
- Latency from the s edge to w high again:
  - MOV imm: 2 cycles.
  - MOV reg / MVN: 4 cycles.
  - CMP: 4 cycles.
  - ADD / AND: 5 cycles.
- s held high continuously: a new instruction starts on every return to WAIT (one WAIT cycle between instructions).
- write and loads are never high in the same cycle.

Decomposition:
- Shared package (cpu_defs):
  - opcode/op constants.
  - state encodings.
  - vsel codes (VSEL_C=00, VSEL_IMM8=10).
  - ALUop and shift codes matching the existing datapath definitions.
  - Register-index constants R0..R7.
- Sub-module cpu_decoder: combinational. Maps IR to opcode, op, Rn, Rd, Rm, sh, sximm8, sximm5 and an instruction-class enum.
- cpu_controller: holds the IR and the FSM.

Test Plan:
1. Apply reset_n=0 mid-run, cycle 3 of an ADD -> w=1, IR=0000, all strobes 0 immediately (async); nothing is written afterwards.
2. in=D007 (MOV R0,#7), load+s together -> next cycle DECODE; following cycle writenum=000, vsel=10, write=1, sximm8=0007; w=1 one cycle later.
3. in=D5FD (MOV R5,#-3) -> sximm8=FFFD, writenum=101 during WRITE_IMM.
4. in=A148 (ADD R2,R1,R0,LSL#1):
   - GET_A: readnum=001, loada=1.
   - GET_B: readnum=000, loadb=1.
   - CALC: shift=01, ALUop=00, asel=0, loadc=1.
   - WRITE_REG: writenum=010, vsel=00, write=1.
   - w high 5 cycles after s.
5. in=AB03 (CMP R3,R3) -> CALC has loads=1, loadc=0, ALUop=01; no write cycle; w returns after 4 cycles. in=C027 (MOV R1,R7) -> CALC asel=1, then writenum=001.
6. Pulse load with in=FFFF while in GET_B -> IR unchanged, current instruction completes. Opcode 111 -> DECODE then WAIT, with no write or loads.
